// File: rtl/sdspi_ctrl_pkg.sv
// rtl/sdspi_ctrl_pkg.sv - shared types and constants for the SD SPI-mode command controller
package sdspi_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONF,
        S_CS_SETUP,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_CMD,
        PH_POLL,
        PH_TAIL
    } phase_t;

    localparam int         CMD_FRAME_BYTES = 6;
    localparam logic [7:0] SPI_FILL        = 8'hFF;
    localparam logic [1:0] CMD_START_BITS  = 2'b01;
    localparam logic       CMD_END_BIT     = 1'b1;

endpackage

// File: rtl/sdspi_byte_xfer.sv
// rtl/sdspi_byte_xfer.sv - one byte handshake with the SPI master (strobe, busy high, busy low)
module sdspi_byte_xfer
    import sdspi_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       load,
    input  logic [7:0] load_byte,
    output logic       done,
    output logic [7:0] rx_byte,
    input  logic       spi_busy,
    input  logic [7:0] spi_data_out,
    output logic [7:0] spi_data_in,
    output logic       spi_w_data
);

    state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            done        <= 1'b0;
            rx_byte     <= SPI_FILL;
            spi_data_in <= SPI_FILL;
            spi_w_data  <= 1'b0;
        end else begin
            done       <= 1'b0;
            spi_w_data <= 1'b0;
            case (state)
                S_ISSUE: state <= S_WAIT_HI;
                S_WAIT_HI: begin
                    if (spi_busy) state <= S_WAIT_LO;
                end
                // The master's received byte is only final once busy drops.
                S_WAIT_LO: begin
                    if (!spi_busy) begin
                        rx_byte <= spi_data_out;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    if (start) begin
                        spi_data_in <= tx_byte;
                        spi_w_data  <= 1'b1;
                        state       <= S_ISSUE;
                    end else if (load) begin
                        spi_data_in <= load_byte;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/sdspi_cmd_ctrl.sv
// rtl/sdspi_cmd_ctrl.sv - issues one SD SPI-mode command frame and collects the R1 response
module sdspi_cmd_ctrl
    import sdspi_ctrl_pkg::*;
#(
    parameter int RESP_POLL_MAX = 8,
    parameter int TAIL_BYTES    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_div,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    output logic        cmd_ready,
    output logic        resp_valid,
    output logic [7:0]  resp_r1,
    output logic        resp_timeout,
    output logic [7:0]  spi_data_in,
    input  logic [7:0]  spi_data_out,
    output logic        spi_w_data,
    output logic        spi_w_conf,
    output logic        spi_ss,
    input  logic        spi_busy
);

    state_t      state;
    phase_t      phase;
    logic [2:0]  byte_cnt;
    logic [7:0]  poll_cnt;
    logic [5:0]  index_q;
    logic [31:0] arg_q;
    logic [6:0]  crc_q;
    logic [7:0]  r1_q;
    logic        timeout_q;
    logic        xfer_start;
    logic        xfer_done;
    logic        xfer_load;
    logic [7:0]  xfer_tx;
    logic [7:0]  xfer_rx;
    logic [7:0]  xfer_load_byte;
    logic        poll_end;
    logic [7:0]  poll_r1;

    // The byte port doubles as the divider bus during CONF, then returns to the fill pattern.
    assign xfer_load      = ((state == S_IDLE) && cfg_we) || (state == S_CONF);
    assign xfer_load_byte = (state == S_CONF) ? SPI_FILL : cfg_div;
    assign poll_end       = !xfer_rx[7] || (poll_cnt == 8'(RESP_POLL_MAX));
    assign poll_r1        = xfer_rx[7] ? SPI_FILL : xfer_rx;

    always_comb begin
        xfer_tx = SPI_FILL;
        if (phase == PH_CMD) begin
            case (byte_cnt)
                3'd0:    xfer_tx = {CMD_START_BITS, index_q};
                3'd1:    xfer_tx = arg_q[31:24];
                3'd2:    xfer_tx = arg_q[23:16];
                3'd3:    xfer_tx = arg_q[15:8];
                3'd4:    xfer_tx = arg_q[7:0];
                3'd5:    xfer_tx = {crc_q, CMD_END_BIT};
                default: xfer_tx = SPI_FILL;
            endcase
        end
    end

    sdspi_byte_xfer u_xfer (
        .clk          (clk),
        .rst          (rst),
        .start        (xfer_start),
        .tx_byte      (xfer_tx),
        .load         (xfer_load),
        .load_byte    (xfer_load_byte),
        .done         (xfer_done),
        .rx_byte      (xfer_rx),
        .spi_busy     (spi_busy),
        .spi_data_out (spi_data_out),
        .spi_data_in  (spi_data_in),
        .spi_w_data   (spi_w_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            phase        <= PH_CMD;
            byte_cnt     <= 3'd0;
            poll_cnt     <= 8'd0;
            index_q      <= 6'd0;
            arg_q        <= 32'd0;
            crc_q        <= 7'd0;
            r1_q         <= SPI_FILL;
            timeout_q    <= 1'b0;
            xfer_start   <= 1'b0;
            cmd_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_r1      <= SPI_FILL;
            resp_timeout <= 1'b0;
            spi_w_conf   <= 1'b0;
            spi_ss       <= 1'b1;
        end else begin
            xfer_start <= 1'b0;
            resp_valid <= 1'b0;
            spi_w_conf <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_we) begin
                        spi_w_conf <= 1'b1;
                        cmd_ready  <= 1'b0;
                        state      <= S_CONF;
                    end else if (cmd_start) begin
                        index_q    <= cmd_index;
                        arg_q      <= cmd_arg;
                        crc_q      <= cmd_crc;
                        byte_cnt   <= 3'd0;
                        poll_cnt   <= 8'd0;
                        phase      <= PH_CMD;
                        cmd_ready  <= 1'b0;
                        spi_ss     <= 1'b0;
                        xfer_start <= 1'b1;
                        state      <= S_CS_SETUP;
                    end
                end
                S_CONF: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                S_CS_SETUP: state <= S_ISSUE;
                S_ISSUE: begin
                    if (xfer_done) begin
                        case (phase)
                            PH_CMD: begin
                                xfer_start <= 1'b1;
                                if (byte_cnt == 3'(CMD_FRAME_BYTES - 1)) begin
                                    phase    <= PH_POLL;
                                    poll_cnt <= 8'd1;
                                end else begin
                                    byte_cnt <= byte_cnt + 3'd1;
                                end
                            end
                            PH_POLL: begin
                                if (poll_end) begin
                                    r1_q      <= poll_r1;
                                    timeout_q <= xfer_rx[7];
                                    if (TAIL_BYTES == 0) begin
                                        resp_valid   <= 1'b1;
                                        resp_r1      <= poll_r1;
                                        resp_timeout <= xfer_rx[7];
                                        spi_ss       <= 1'b1;
                                        state        <= S_DONE;
                                    end else begin
                                        phase      <= PH_TAIL;
                                        byte_cnt   <= 3'd0;
                                        xfer_start <= 1'b1;
                                    end
                                end else begin
                                    poll_cnt   <= poll_cnt + 8'd1;
                                    xfer_start <= 1'b1;
                                end
                            end
                            default: begin
                                if (byte_cnt == 3'(TAIL_BYTES - 1)) begin
                                    resp_valid   <= 1'b1;
                                    resp_r1      <= r1_q;
                                    resp_timeout <= timeout_q;
                                    spi_ss       <= 1'b1;
                                    state        <= S_DONE;
                                end else begin
                                    byte_cnt   <= byte_cnt + 3'd1;
                                    xfer_start <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdspi_cmd_ctrl.sv
// tb/tb_sdspi_cmd_ctrl.sv - SPI master + SD slave model bench for sdspi_cmd_ctrl
module tb_sdspi_cmd_ctrl;

    localparam int POLL_MAX = 8;
    localparam int TAIL     = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_div = 8'h00;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic [6:0]  cmd_crc = 7'd0;
    logic        cmd_ready;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic        resp_timeout;
    logic [7:0]  spi_data_in;
    logic [7:0]  spi_data_out;
    logic        spi_w_data;
    logic        spi_w_conf;
    logic        spi_ss;
    logic        spi_busy;

    sdspi_cmd_ctrl #(.RESP_POLL_MAX(POLL_MAX), .TAIL_BYTES(TAIL)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_div      (cfg_div),
        .cmd_start    (cmd_start),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .cmd_crc      (cmd_crc),
        .cmd_ready    (cmd_ready),
        .resp_valid   (resp_valid),
        .resp_r1      (resp_r1),
        .resp_timeout (resp_timeout),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_w_data   (spi_w_data),
        .spi_w_conf   (spi_w_conf),
        .spi_ss       (spi_ss),
        .spi_busy     (spi_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] mosi_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] conf_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] poll_resp[$];
    int xfer_t = 2;
    int busy_left = 0;
    logic [7:0] pending = 8'hFF;
    int ss_bad = 0;
    int rv_count = 0;

    // SPI master and SD slave: the slave answers FF during the frame, then pops the poll script.
    always @(posedge clk) begin
        if (rst) begin
            spi_busy     <= 1'b0;
            spi_data_out <= 8'hFF;
            busy_left = 0;
        end else begin
            if (spi_busy) begin
                busy_left--;
                if (busy_left <= 0) begin
                    spi_busy     <= 1'b0;
                    spi_data_out <= pending;
                end
            end else if (spi_w_data) begin
                if (spi_ss) begin
                    ss_bad++;
                end else begin
                    mosi_q.push_back(spi_data_in);
                    if (mosi_q.size() <= 6 || miso_q.size() == 0) pending = 8'hFF;
                    else pending = miso_q.pop_front();
                    spi_data_out <= 8'h00;
                    spi_busy     <= 1'b1;
                    busy_left = xfer_t;
                end
            end
            if (spi_w_conf) conf_q.push_back(spi_data_in);
            if (resp_valid) rv_count++;
            if (spi_busy && spi_ss) ss_bad++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected MOSI stream and result from the frame format and the poll script.
    task automatic build_exp(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                             output logic [7:0] r1, output logic tmo);
        int c;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'h40 + {2'b00, idx});
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'(arg >> (8 * i)));
        c = int'(crc);
        exp_q.push_back(8'(c * 2 + 1));
        r1  = 8'hFF;
        tmo = 1'b1;
        for (int k = 1; k <= POLL_MAX; k++) begin
            b = (k <= poll_resp.size()) ? poll_resp[k-1] : 8'hFF;
            exp_q.push_back(8'hFF);
            if (b < 8'h80) begin
                r1  = b;
                tmo = 1'b0;
                break;
            end
        end
        for (int t = 0; t < TAIL; t++) exp_q.push_back(8'hFF);
    endtask

    task automatic run_case(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                            input bit poke, output logic [7:0] r1, output logic tmo, output int nb);
        int n;
        int rv0;
        mosi_q.delete();
        conf_q.delete();
        ss_bad = 0;
        rv0 = rv_count;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        cmd_index = idx;
        cmd_arg   = arg;
        cmd_crc   = crc;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        chk("cmd_ready_low", cmd_ready, 0);
        if (poke) begin
            n = 0;
            while (mosi_q.size() < 2 && n < 500) begin @(negedge clk); n++; end
            cmd_start = 1'b1;
            cmd_index = 6'h3F;
            cfg_we    = 1'b1;
            cfg_div   = 8'h55;
            @(negedge clk);
            cmd_start = 1'b0;
            cfg_we    = 1'b0;
        end
        n = 0;
        while (resp_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        chk("resp_valid_seen", resp_valid, 1);
        r1  = resp_r1;
        tmo = resp_timeout;
        chk("ss_high_at_done", spi_ss, 1);
        @(negedge clk);
        chk("resp_valid_one_cycle", resp_valid, 0);
        chk("cmd_ready_after", cmd_ready, 1);
        chk("resp_valid_count", rv_count - rv0, 1);
        chk("ss_low_during_frame", ss_bad, 0);
        chk("r1_held", resp_r1, r1);
        if (poke) chk("no_conf_mid_frame", conf_q.size(), 0);
        nb = mosi_q.size();
        chk("mosi_len", nb, exp_q.size());
        for (int i = 0; i < nb && i < exp_q.size(); i++) chk($sformatf("mosi_byte%0d", i), mosi_q[i], exp_q[i]);
    endtask

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic [79:0] resp;
        logic [7:0]  r1;
        logic        tmo;
        logic [7:0]  nbytes;
        logic [7:0]  b0;
        logic [7:0]  b5;
    } tv_t;

    tv_t tv[6];

    task automatic load_script(input logic [79:0] r);
        poll_resp.delete();
        for (int j = 0; j < 10; j++) poll_resp.push_back(r[79 - 8 * j -: 8]);
        miso_q = poll_resp;
    endtask

    initial begin
        logic [7:0] r1;
        logic       tmo;
        logic [7:0] m_r1;
        logic       m_tmo;
        int         nb;
        int         n;
        int         rv0;
        int         p;

        tv[0] = '{6'd0,  32'h0000_0000, 7'h4A, {8'hFF, 8'hFF, 8'h01, {56{1'b1}}}, 8'h01, 1'b0, 8'd10, 8'h40, 8'h95};
        tv[1] = '{6'd8,  32'h0000_01AA, 7'h43, {8'h01, {72{1'b1}}},              8'h01, 1'b0, 8'd8,  8'h48, 8'h87};
        tv[2] = '{6'd17, 32'h1234_5678, 7'h2A, {80{1'b1}},                        8'hFF, 1'b1, 8'd15, 8'h51, 8'h55};
        tv[3] = '{6'd55, 32'h0000_0000, 7'h32, {{7{8'hFF}}, 8'h05, 16'hFFFF},    8'h05, 1'b0, 8'd15, 8'h77, 8'h65};
        tv[4] = '{6'd1,  32'h4000_0000, 7'h7C, {{8{8'hFF}}, 8'h00, 8'hFF},       8'hFF, 1'b1, 8'd15, 8'h41, 8'hF9};
        tv[5] = '{6'd41, 32'h4030_0000, 7'h01, {8'h80, 8'hFE, 8'h7F, {56{1'b1}}}, 8'h7F, 1'b0, 8'd10, 8'h69, 8'h03};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_r1", resp_r1, 8'hFF);
        chk("rst_resp_timeout", resp_timeout, 0);
        chk("rst_spi_data_in", spi_data_in, 8'hFF);
        chk("rst_spi_w_data", spi_w_data, 0);
        chk("rst_spi_w_conf", spi_w_conf, 0);
        chk("rst_spi_ss", spi_ss, 1);

        for (int i = 0; i < 6; i++) begin
            xfer_t = 2 + i % 2;
            load_script(tv[i].resp);
            build_exp(tv[i].idx, tv[i].arg, tv[i].crc, m_r1, m_tmo);
            run_case(tv[i].idx, tv[i].arg, tv[i].crc, i == 0, r1, tmo, nb);
            chk($sformatf("tv%0d_r1", i), r1, tv[i].r1);
            chk($sformatf("tv%0d_timeout", i), tmo, tv[i].tmo);
            chk($sformatf("tv%0d_nbytes", i), nb, tv[i].nbytes);
            if (nb >= 6) begin
                chk($sformatf("tv%0d_byte0", i), mosi_q[0], tv[i].b0);
                chk($sformatf("tv%0d_byte5", i), mosi_q[5], tv[i].b5);
            end
        end

        // cfg_we wins over a simultaneous cmd_start, which is dropped.
        mosi_q.delete();
        conf_q.delete();
        rv0 = rv_count;
        cfg_we    = 1'b1;
        cfg_div   = 8'h03;
        cmd_start = 1'b1;
        cmd_index = 6'd0;
        @(negedge clk);
        cfg_we    = 1'b0;
        cmd_start = 1'b0;
        chk("conf_strobe", spi_w_conf, 1);
        chk("conf_data", spi_data_in, 8'h03);
        chk("conf_not_ready", cmd_ready, 0);
        @(negedge clk);
        chk("conf_one_cycle", spi_w_conf, 0);
        repeat (20) @(negedge clk);
        chk("conf_count", conf_q.size(), 1);
        if (conf_q.size() > 0) chk("conf_value", conf_q[0], 8'h03);
        chk("conf_no_xfer", mosi_q.size(), 0);
        chk("conf_ready_back", cmd_ready, 1);
        chk("conf_fill_back", spi_data_in, 8'hFF);
        chk("conf_ss_high", spi_ss, 1);
        chk("conf_no_resp", rv_count - rv0, 0);

        // Reset during byte 3 of a frame.
        load_script({8'hFF, 8'hFF, 8'h01, {56{1'b1}}});
        mosi_q.delete();
        rv0 = rv_count;
        cmd_index = 6'd0;
        cmd_arg   = 32'd0;
        cmd_crc   = 7'h4A;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        n = 0;
        while (mosi_q.size() < 3 && n < 500) begin @(negedge clk); n++; end
        chk("rst_mid_reached_byte3", mosi_q.size(), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ss", spi_ss, 1);
        chk("rst_mid_ready", cmd_ready, 1);
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_fill", spi_data_in, 8'hFF);
        repeat (30) @(negedge clk);
        chk("rst_mid_no_resp", rv_count - rv0, 0);
        chk("rst_mid_no_more_bytes", mosi_q.size(), 3);
        load_script({8'hFF, 8'hFF, 8'h01, {56{1'b1}}});
        build_exp(6'd0, 32'd0, 7'h4A, m_r1, m_tmo);
        run_case(6'd0, 32'd0, 7'h4A, 1'b0, r1, tmo, nb);
        chk("rst_after_r1", r1, 8'h01);
        chk("rst_after_timeout", tmo, 0);

        // Randomized commands against the model.
        for (int it = 0; it < 16; it++) begin
            logic [5:0]  ridx;
            logic [31:0] rarg;
            logic [6:0]  rcrc;
            xfer_t = $urandom_range(1, 4);
            ridx = 6'($urandom);
            rarg = $urandom;
            rcrc = 7'($urandom);
            p = $urandom_range(1, 10);
            poll_resp.delete();
            for (int k = 1; k < p; k++) poll_resp.push_back(8'($urandom) | 8'h80);
            poll_resp.push_back(8'($urandom) & 8'h7F);
            miso_q = poll_resp;
            build_exp(ridx, rarg, rcrc, m_r1, m_tmo);
            run_case(ridx, rarg, rcrc, (it % 4) == 0, r1, tmo, nb);
            chk($sformatf("rand%0d_r1", it), r1, m_r1);
            chk($sformatf("rand%0d_timeout", it), tmo, m_tmo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdspi_cmd_ctrl.md
Name: sdspi_cmd_ctrl

Overview:
- Sequences the byte-level SPI master to issue one SD-card SPI-mode command frame and collect its R1 response.
- Sequence: chip-select setup, 6 command bytes, 0xFF polling bytes until a byte with bit7=0 arrives (or a poll limit is hit), one trailing 0xFF byte, then chip-select release.
- Also forwards clock-divider configuration to the SPI master.
- Sits between the SD host logic and the SPI master's byte port (data_in/data_out/w_data/w_conf/ss_in/busy).

Parameters:
- RESP_POLL_MAX, 8: maximum number of 0xFF poll bytes before a response timeout; legal range 1..255.
- TAIL_BYTES, 1: number of 0xFF bytes sent after the response while CS is still asserted; legal range 0..3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  one-cycle request to load the SPI clock divider; accepted only in IDLE
- cfg_div  in  8  divider value, forwarded on spi_data_in
- cmd_start  in  1  start command; accepted only when cmd_ready=1
- cmd_index  in  6  SD command index
- cmd_arg  in  32  command argument, sent MSB first
- cmd_crc  in  7  CRC7 of the frame
- cmd_ready  out  1  high in IDLE only
- resp_valid  out  1  one-cycle pulse at completion
- resp_r1  out  8  captured R1 byte; 0xFF on timeout; held until the next completion
- resp_timeout  out  1  valid with resp_valid; held until the next completion
- spi_data_in  out  8  byte to the SPI master
- spi_data_out  in  8  byte received by the SPI master
- spi_w_data  out  1  one-cycle transfer strobe
- spi_w_conf  out  1  one-cycle config strobe
- spi_ss  out  1  chip select, active low
- spi_busy  in  1  SPI master busy

Behaviour:
- All outputs are registered.
- Reset values: cmd_ready=1, resp_valid=0, resp_r1=8'hFF, resp_timeout=0, spi_data_in=8'hFF, spi_w_data=0, spi_w_conf=0, spi_ss=1.
- States: IDLE, CONF, CS_SETUP, ISSUE, WAIT_HI, WAIT_LO, DONE.
- Phase register: CMD, POLL, TAIL. Byte counter: 3 bits. Poll counter: 8 bits.
- IDLE:
  - spi_ss=1 and spi_data_in=FF, so the SPI master's free-running clocks shift out ones.
  - cfg_we -> CONF. cfg_we has priority over a simultaneous cmd_start; that cmd_start is dropped.
  - cmd_start -> latch index/arg/crc; clear the byte and poll counters; phase=CMD; go to CS_SETUP.
- CONF: spi_w_conf=1 and spi_data_in=cfg_div for exactly 1 cycle -> IDLE.
- CS_SETUP:
  - spi_ss=0 for 1 cycle before the first strobe. The master ignores w_data while ss_in=1.
  - spi_ss then stays 0 until DONE.
- ISSUE:
  - Drive spi_data_in with the current byte and spi_w_data=1 for 1 cycle -> WAIT_HI.
  - CMD bytes 0..5: {2'b01,index}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc,1'b1}.
  - POLL and TAIL bytes: 8'hFF.
  - spi_data_in is held until the next ISSUE.
- WAIT_HI: wait for spi_busy=1; the master raises it the cycle after the strobe.
- WAIT_LO: wait for spi_busy=0. On that cycle spi_data_out is final; sample it and decide the next step:
  - CMD, byte<5: byte++ -> ISSUE.
  - CMD, byte=5: phase=POLL -> ISSUE.
  - POLL, sample bit7=0: resp_r1=sample, resp_timeout=0, phase=TAIL.
  - POLL, poll count reaches RESP_POLL_MAX with bit7=1: resp_r1=FF, resp_timeout=1, phase=TAIL.
  - POLL otherwise: poll++ -> ISSUE.
  - TAIL: done after TAIL_BYTES bytes. With TAIL_BYTES=0, go directly to DONE on leaving POLL.
- DONE: spi_ss=1, resp_valid=1 for 1 cycle -> IDLE, with cmd_ready=1 on the following cycle.
- The first poll byte counts as poll 1. A response on poll RESP_POLL_MAX is accepted, not a timeout.
- cmd_start or cfg_we outside IDLE is ignored with no side effects.
- Reset mid-operation returns all outputs to reset values on the next cycle. The pending command is discarded; no resp_valid.
- Minimum total latency, from cmd_start to resp_valid: 2 + 6·T + P·T + TAIL_BYTES·T + 1 cycles, where T is the per-byte handshake time and P is the number of polls.

Decomposition:
- Package sdspi_ctrl_pkg holds:
  - the state_t and phase_t enums;
  - CMD_FRAME_BYTES=6, SPI_FILL=8'hFF, CMD_START_BITS=2'b01, CMD_END_BIT=1'b1.
- Sub-module sdspi_byte_xfer implements ISSUE/WAIT_HI/WAIT_LO. Interface: start + tx byte in; done pulse + rx byte out.
- The top level keeps the phase and counter logic and the frame-byte mux.

Test Plan:
- Bench is the SPI master plus an SD slave model, with RESP_POLL_MAX=8 and TAIL_BYTES=1.
- CMD0 (index 0, arg 0, crc 7'h4A); slave returns FF, FF, 01 -> MOSI bytes 40 00 00 00 00 95 FF FF FF FF; resp_r1=01, resp_timeout=0; exactly one resp_valid; spi_ss low throughout, high after.
- CMD8 (arg 32'h000001AA, crc 7'h43); slave answers 01 on poll 1 -> bytes 48 00 00 01 AA 87 FF FF; resp_r1=01.
- Slave always FF -> exactly 8 poll bytes plus 1 tail byte; resp_r1=FF, resp_timeout=1.
- cfg_we with cfg_div=3 in the same cycle as cmd_start -> one spi_w_conf pulse carrying 03; no spi_w_data; cmd_ready returns; the command is not executed.
- cmd_start pulsed mid-frame is ignored. rst asserted during byte 3 -> next cycle spi_ss=1, cmd_ready=1, no resp_valid; a following CMD0 completes normally.
